// File: rtl/mux_2_1_rr_arbiter_if.sv
// Handshake bundle between two requesters, the round-robin arbiter and the downstream 2:1 MUX.
// The arbiter uses the slave modport; whoever drives requests uses the master modport.

interface mux_2_1_rr_arbiter_if;
   logic Enable_In;
   logic Request_0_In;
   logic Request_1_In;
   logic Done_In;
   logic Grant_0_Out;
   logic Grant_1_Out;
   logic Select_Out;
   logic MUX_Enable_Out;
   logic Busy_Out;

   modport master (
      output Enable_In,
      output Request_0_In,
      output Request_1_In,
      output Done_In,
      input  Grant_0_Out,
      input  Grant_1_Out,
      input  Select_Out,
      input  MUX_Enable_Out,
      input  Busy_Out
   );

   modport slave (
      input  Enable_In,
      input  Request_0_In,
      input  Request_1_In,
      input  Done_In,
      output Grant_0_Out,
      output Grant_1_Out,
      output Select_Out,
      output MUX_Enable_Out,
      output Busy_Out
   );
endinterface

// File: rtl/mux_2_1_rr_arbiter.sv
// Two-channel round-robin arbiter driving the select/enable of a downstream 2:1 MUX.
// Define MUX_ARB_HOLD_LIMIT_EN to cap a contended grant at MAX_HOLD consecutive cycles.

module mux_2_1_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic                       Clock_In,
   input logic                       Reset_N_In,
   mux_2_1_rr_arbiter_if.slave       bus
);

   if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : gen_bad_max_hold
      $error("MAX_HOLD must lie in 2..256");
   end

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StGrant0 = 2'd1,
      StGrant1 = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   last_grant_q, last_grant_d;
   logic   select_q, select_d;
   logic   hold_expired;
   logic   release_0;
   logic   release_1;

`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam int unsigned CntW = $clog2(MAX_HOLD);

   logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

   // Counter value k means the current grant has been visible for k+1 cycles.
   assign hold_expired = (hold_cnt_q == CntW'(MAX_HOLD - 1));
`else
   assign hold_expired = 1'b0;
`endif

   // Hold expiry only releases when the other channel is actually waiting.
   assign release_0 = bus.Done_In | ~bus.Request_0_In | (hold_expired & bus.Request_1_In);
   assign release_1 = bus.Done_In | ~bus.Request_1_In | (hold_expired & bus.Request_0_In);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      select_d     = select_q;

      if (!bus.Enable_In) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.Request_0_In && (!bus.Request_1_In || last_grant_q)) begin
                  state_d = StGrant0;
               end else if (bus.Request_1_In) begin
                  state_d = StGrant1;
               end
            end
            StGrant0: begin
               if (release_0) begin
                  state_d = bus.Request_1_In ? StGrant1 : StIdle;
               end
            end
            StGrant1: begin
               if (release_1) begin
                  state_d = bus.Request_0_In ? StGrant0 : StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (state_d == StGrant0 && state_q != StGrant0) begin
         last_grant_d = 1'b0;
         select_d     = 1'b0;
      end else if (state_d == StGrant1 && state_q != StGrant1) begin
         last_grant_d = 1'b1;
         select_d     = 1'b1;
      end
   end

`ifdef MUX_ARB_HOLD_LIMIT_EN
   always_comb begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      if (state_d == StIdle || state_d != state_q || hold_expired) begin
         hold_cnt_d = '0;
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         select_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         select_q     <= select_d;
      end
   end

   assign bus.Grant_0_Out    = (state_q == StGrant0);
   assign bus.Grant_1_Out    = (state_q == StGrant1);
   assign bus.Select_Out     = select_q;
   assign bus.MUX_Enable_Out = (state_q == StGrant0) | (state_q == StGrant1);
   assign bus.Busy_Out       = (state_q == StGrant0) | (state_q == StGrant1);

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// Scoreboard bench for mux_2_1_rr_arbiter: expected output vectors are queued when inputs are
// driven and popped one edge later. Vector layout is {Grant_0, Grant_1, Select, MUX_En, Busy}.

module tb_mux_2_1_rr_arbiter;

   localparam int unsigned HOLD = 8;
`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam bit HoldEn = 1'b1;
`else
   localparam bit HoldEn = 1'b0;
`endif

   localparam logic [4:0] Idle0 = 5'b00000;
   localparam logic [4:0] Idle1 = 5'b00100;
   localparam logic [4:0] G0    = 5'b10011;
   localparam logic [4:0] G1    = 5'b01111;

   logic Clock_In;
   logic Reset_N_In;

   mux_2_1_rr_arbiter_if bus_if ();

   mux_2_1_rr_arbiter #(
      .MAX_HOLD (HOLD)
   ) dut (
      .Clock_In   (Clock_In),
      .Reset_N_In (Reset_N_In),
      .bus        (bus_if)
   );

   initial Clock_In = 1'b0;
   always #5 Clock_In = ~Clock_In;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [4:0] exp_q [$];
   logic [4:0] got;
   logic [4:0] exp_v;

   // Reference model state: owner -1 idle, 0 or 1 granted channel.
   int   m_owner;
   logic m_last;
   logic m_sel;
   int   m_cnt;

   function automatic logic [4:0] sample();
      return {bus_if.Grant_0_Out, bus_if.Grant_1_Out, bus_if.Select_Out,
              bus_if.MUX_Enable_Out, bus_if.Busy_Out};
   endfunction

   function automatic logic [4:0] model_vec();
      if (m_owner == 0) return G0;
      if (m_owner == 1) return G1;
      return {2'b00, m_sel, 2'b00};
   endfunction

   task automatic drive(input logic en, input logic r0, input logic r1, input logic d);
      bus_if.Enable_In    = en;
      bus_if.Request_0_In = r0;
      bus_if.Request_1_In = r1;
      bus_if.Done_In      = d;
   endtask

   // Drives {en,r0,r1,done} at the falling edge, queues the expectation, waits past the next edge.
   task automatic tick(input logic [8:0] v);
      @(negedge Clock_In);
      drive(v[8], v[7], v[6], v[5]);
      exp_q.push_back(v[4:0]);
      @(posedge Clock_In);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      Reset_N_In = 1'b0;
      @(posedge Clock_In);
      @(posedge Clock_In);
      #1;
      Reset_N_In = 1'b1;
      m_owner = -1;
      m_last  = 1'b1;
      m_sel   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_step(input logic en, input logic r0, input logic r1, input logic d);
      int   nxt     = m_owner;
      logic mine    = 1'b0;
      logic other   = 1'b0;
      bit   expired = 1'b0;
      if (!en) begin
         nxt = -1;
      end else if (m_owner < 0) begin
         if (r0 && r1) nxt = m_last ? 0 : 1;
         else if (r0)  nxt = 0;
         else if (r1)  nxt = 1;
      end else begin
         mine    = (m_owner == 0) ? r0 : r1;
         other   = (m_owner == 0) ? r1 : r0;
         expired = HoldEn && (m_cnt + 1 == int'(HOLD));
         if (d || !mine || (expired && other)) nxt = other ? 1 - m_owner : -1;
      end
      if (nxt >= 0 && nxt != m_owner) begin
         m_last = nxt[0];
         m_sel  = nxt[0];
         m_cnt  = 0;
      end else if (nxt >= 0) begin
         m_cnt = expired ? 0 : m_cnt + 1;
      end else begin
         m_cnt = 0;
      end
      m_owner = nxt;
   endtask

   task automatic test_reset();
      logic [8:0] tbl [2];
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      Reset_N_In = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(Idle0);
         @(posedge Clock_In);
         #1;
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: got %b, expected %b", i, got, exp_v);
         end
      end
      Reset_N_In = 1'b1;
      // Enable low after release must not grant; both requests then pick channel 0 first.
      tbl = '{{4'b0110, Idle0}, {4'b1110, G0}};
      for (int i = 0; i < 2; i++) begin
         tick(tbl[i]);
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release step %0d: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [8:0] tbl [15];
      do_reset();
      tbl = '{{4'b1110, G0},    {4'b1111, G1},    {4'b1110, G1},    {4'b1010, G1},
              {4'b1100, G0},    {4'b1000, Idle0}, {4'b1001, Idle0}, {4'b1010, G1},
              {4'b1000, Idle1}, {4'b1110, G0},    {4'b1111, G1},    {4'b1111, G0},
              {4'b1000, Idle0}, {4'b1110, G1},    {4'b1001, Idle1}};
      for (int i = 0; i < 15; i++) begin
         tick(tbl[i]);
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL round_robin step %0d: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_single_hold();
      do_reset();
      for (int i = 0; i < 21; i++) begin
         tick({4'b1010, G1});
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL single_hold cyc %0d: got %b, expected %b", i, got, exp_v);
         end
      end
      tick({4'b1000, Idle1});
      got   = sample();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL single_drop: got %b, expected %b", got, exp_v);
      end
   endtask

   task automatic test_hold_limit();
      logic [4:0] e;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         e = (!HoldEn || ((k / int'(HOLD)) % 2 == 0)) ? G0 : G1;
         tick({4'b1110, e});
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL hold_limit cyc %0d: got %b, expected %b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [8:0] tbl [7];
      do_reset();
      tbl = '{{4'b1010, G1},    {4'b1010, G1},    {4'b0110, Idle1}, {4'b0110, Idle1},
              {4'b1110, G0},    {4'b0111, Idle0}, {4'b1110, G1}};
      for (int i = 0; i < 7; i++) begin
         tick(tbl[i]);
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL enable_drop step %0d: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [8:0] tbl [3];
      do_reset();
      tick({4'b1010, G1});
      tick({4'b1010, G1});
      for (int i = 0; i < 2; i++) begin
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL async_pre step %0d: got %b, expected %b", i, got, exp_v);
         end
      end
      // Mid-cycle pulse: outputs must clear before the next clock edge arrives.
      #2;
      Reset_N_In = 1'b0;
      exp_q.push_back(Idle0);
      #1;
      got   = sample();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL async_reset_no_edge: got %b, expected %b", got, exp_v);
      end
      tbl = '{{4'b1110, Idle0}, {4'b1110, G0}, {4'b1110, G0}};
      for (int i = 0; i < 3; i++) begin
         if (i == 1) Reset_N_In = 1'b1;
         tick(tbl[i]);
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL async_release step %0d: got %b, expected %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_random();
      logic en, r0, r1, d;
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         r0 = $urandom_range(0, 1) != 0;
         r1 = $urandom_range(0, 1) != 0;
         d  = ($urandom_range(0, 4) == 0);
         model_step(en, r0, r1, d);
         tick({en, r0, r1, d, model_vec()});
         got   = sample();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %b, expected %b", i, got, exp_v);
         end
         n_checks++;
         if ((got[4] && got[3]) || (got[1] && got[2] !== got[3])) begin
            n_fail++;
            $display("FAIL random_onehot_select cyc %0d: got %b, expected one-hot with matching select",
                     i, got);
         end
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      Reset_N_In = 1'b0;
      m_owner    = -1;
      m_last     = 1'b1;
      m_sel      = 1'b0;
      m_cnt      = 0;
      test_reset();
      test_round_robin();
      test_single_hold();
      test_hold_limit();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
